// File: rtl/alien_fire_ctrl.sv
// alien_fire_ctrl
// Enemy shot scheduler. It waits a randomised cooldown of MIN_GAP plus up to
// 2^GAP_BITS-1 extra frame ticks. It then scans the alien alive mask, one
// column per cycle, starting from a random column. The first living column it
// finds is offered to the bullet spawner over a valid/ready handshake.
//
// Optional feature macro: ALIEN_FIRE_AIMED_EN
//   When defined, the start column is taken from player_col_i (clamped to the
//   last column) whenever rand_i[CW] is set. Otherwise the start column is
//   random. When not defined, player_col_i is ignored.
module alien_fire_ctrl #(
  parameter int LEN      = 16,
  parameter int COLS     = 11,
  parameter int MIN_GAP  = 8,
  parameter int GAP_BITS = 5,
  localparam int CW      = $clog2(COLS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            tick_i,
  input  logic [LEN-1:0]  rand_i,
  input  logic [COLS-1:0] alive_i,
  input  logic [CW-1:0]   player_col_i,
  output logic            fire_valid_o,
  output logic [CW-1:0]   fire_col_o,
  input  logic            fire_ready_i
);

  // Cooldown counter must hold MIN_GAP plus the largest random extra gap.
  localparam int CNT_W = $clog2(MIN_GAP + 2**GAP_BITS);

  localparam logic [CW:0]      COLS_X   = COLS[CW:0];
  localparam logic [CW-1:0]    LAST_COL = CW'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_GAP);

  typedef enum logic [1:0] {
    COOL  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     miss_q, miss_d;
  logic [CW-1:0]     fire_col_q, fire_col_d;
  logic              fire_valid_q, fire_valid_d;

  logic [CW-1:0]     start_col;
  logic [CNT_W-1:0]  reload_cnt;

  // Fold a CW-bit random value into 0..COLS-1. Because 2^CW < 2*COLS, one
  // conditional subtraction is always enough.
  function automatic logic [CW-1:0] wrap_col(input logic [CW-1:0] r);
    logic [CW:0] rx;
    rx = {1'b0, r};
    if (rx >= COLS_X) begin
      return CW'(rx - COLS_X);
    end
    return r;
  endfunction

  // Cooldown reload: the minimum gap plus a random extra taken from the top
  // bits of the LFSR word.
  function automatic logic [CNT_W-1:0] reload_val(input logic [GAP_BITS-1:0] g);
    return CNT_MIN + CNT_W'(g);
  endfunction

`ifdef ALIEN_FIRE_AIMED_EN
  // Saturate an out-of-range player column onto the last alien column.
  function automatic logic [CW-1:0] clamp_col(input logic [CW-1:0] c);
    if ({1'b0, c} >= COLS_X) begin
      return LAST_COL;
    end
    return c;
  endfunction

  assign start_col = rand_i[CW] ? clamp_col(player_col_i)
                                : wrap_col(rand_i[CW-1:0]);
`else
  assign start_col = wrap_col(rand_i[CW-1:0]);
`endif

  assign reload_cnt = reload_val(rand_i[LEN-1 -: GAP_BITS]);

  // Only some LFSR bits are consumed, and player_col_i is unused in the
  // default build. This reduction just marks those bits as intentionally
  // unused.
  logic unused_bits;
  assign unused_bits = ^{rand_i, player_col_i};

  // Next-state and output decode. Dropping enable_i wins over every state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    miss_d       = miss_q;
    fire_col_d   = fire_col_q;
    fire_valid_d = fire_valid_q;

    if (!enable_i) begin
      state_d      = COOL;
      cnt_d        = CNT_MIN;
      fire_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        COOL: begin
          if (cnt_q == '0) begin
            state_d = SCAN;
            idx_d   = start_col;
            miss_d  = '0;
          end else if (tick_i) begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        SCAN: begin
          if (alive_i[idx_q]) begin
            fire_col_d   = idx_q;
            fire_valid_d = 1'b1;
            state_d      = OFFER;
          end else if (miss_q == LAST_COL) begin
            // This is the COLS-th consecutive miss, so the mask is empty.
            state_d = COOL;
            cnt_d   = reload_cnt;
          end else begin
            idx_d  = (idx_q == LAST_COL) ? '0 : idx_q + 1'b1;
            miss_d = miss_q + 1'b1;
          end
        end

        OFFER: begin
          // fire_col is held even if that column dies while the offer waits.
          if (fire_ready_i) begin
            fire_valid_d = 1'b0;
            state_d      = COOL;
            cnt_d        = reload_cnt;
          end
        end

        default: begin
          state_d      = COOL;
          cnt_d        = CNT_MIN;
          fire_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= COOL;
      cnt_q        <= CNT_MIN;
      idx_q        <= '0;
      miss_q       <= '0;
      fire_col_q   <= '0;
      fire_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      miss_q       <= miss_d;
      fire_col_q   <= fire_col_d;
      fire_valid_q <= fire_valid_d;
    end
  end

  assign fire_valid_o = fire_valid_q;
  assign fire_col_o   = fire_col_q;

endmodule

// File: tb/tb_alien_fire_ctrl.sv
// Directed testbench for alien_fire_ctrl at its default parameters.
// Inputs change on the falling edge, and outputs are checked on the falling edge.
module tb_alien_fire_ctrl;

  localparam int CW = 4;

`ifdef ALIEN_FIRE_AIMED_EN
  localparam int AIM_COL = 10;
`else
  localparam int AIM_COL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          tick;
  logic [15:0]   rand_w;
  logic [10:0]   alive;
  logic [CW-1:0] player_col;
  logic          fire_valid;
  logic [CW-1:0] fire_col;
  logic          fire_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alien_fire_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .tick_i       (tick),
    .rand_i       (rand_w),
    .alive_i      (alive),
    .player_col_i (player_col),
    .fire_valid_o (fire_valid),
    .fire_col_o   (fire_col),
    .fire_ready_i (fire_ready)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      expect_eq(tag, 32'(fire_valid), 32'd0);
    end
  endtask

  task automatic expect_offer(input string tag, input int col);
    expect_eq({tag, "_vld"}, 32'(fire_valid), 32'd1);
    expect_eq({tag, "_col"}, 32'(fire_col), 32'(col));
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    tick       = 1'b0;
    fire_ready = 1'b0;
    rand_w     = 16'h0000;
    alive      = '0;
    player_col = '0;
    cyc(3);
    expect_eq("rst_vld", 32'(fire_valid), 32'd0);
    expect_eq("rst_col", 32'(fire_col), 32'd0);

    // First shot: cnt 8 -> 0 over 8 ticks, random start 13-11 = 2.
    rst    = 1'b0;
    enable = 1'b1;
    alive  = '1;
    rand_w = 16'h000D;
    run_ticks(8);
    expect_eq("cnt0_vld", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_eq("scan_vld", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_offer("first", 2);

    // Stall with ready low. The column dies but the offer stays stable.
    alive = '0;
    repeat (5) begin
      cyc(1);
      expect_offer("hold", 2);
    end

    // Transfer with rand[15:11]=3: reload 11, next random start 5.
    rand_w     = 16'h1805;
    fire_ready = 1'b1;
    cyc(1);
    expect_eq("xfer_vld", 32'(fire_valid), 32'd0);
    fire_ready = 1'b0;
    alive      = '1;
    run_ticks(10);
    quiet("gap10", 4);
    run_ticks(1);
    expect_eq("gap11_cnt0", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_eq("gap11_scan", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_offer("gap11", 5);

    // Abort during OFFER, then ticks while disabled must be ignored.
    enable = 1'b0;
    cyc(1);
    expect_eq("abort_vld", 32'(fire_valid), 32'd0);
    tick = 1'b1;
    quiet("dis_tick", 5);
    tick = 1'b0;

    // Re-enable with cnt 8. Wrap scan from 9 with only column 0 alive.
    // Ready is raised early and has no effect before OFFER.
    enable = 1'b1;
    rand_w = 16'h0009;
    alive  = 11'b000_0000_0001;
    run_ticks(7);
    quiet("pre_wrap", 3);
    fire_ready = 1'b1;
    run_ticks(1);
    quiet("wrap_scan", 3);
    cyc(1);
    expect_offer("wrap", 0);
    cyc(1);
    expect_eq("early_rdy_xfer", 32'(fire_valid), 32'd0);
    fire_ready = 1'b0;

    // Empty mask: 11 SCAN cycles, then back to COOL with cnt reloaded to 8.
    alive  = '0;
    rand_w = 16'h0000;
    run_ticks(8);
    quiet("empty", 14);
    alive = '1;
    quiet("empty_cool", 3);
    run_ticks(8);
    expect_eq("re_cnt0", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_eq("re_scan", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_offer("after_empty", 0);

    // Aim request: rand[4]=1 and player_col=14. The aimed build clamps the
    // start to 10. The default build uses the random start 0.
    rand_w     = 16'h0010;
    player_col = 4'd14;
    fire_ready = 1'b1;
    cyc(1);
    expect_eq("aim_xfer", 32'(fire_valid), 32'd0);
    fire_ready = 1'b0;
    run_ticks(8);
    expect_eq("aim_cnt0", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_eq("aim_scan", 32'(fire_valid), 32'd0);
    cyc(1);
    expect_offer("aim", AIM_COL);

    // Reset in the middle of an offer.
    rst = 1'b1;
    cyc(1);
    expect_eq("midrst_vld", 32'(fire_valid), 32'd0);
    expect_eq("midrst_col", 32'(fire_col), 32'd0);
    rst    = 1'b0;
    enable = 1'b0;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alien_fire_ctrl.md
# alien_fire_ctrl

Decides when and from which alien column an enemy shot is fired. Sits directly downstream of the 16-bit Galois LFSR, sampling its free-running pseudo-random word for a randomised inter-shot gap and a random start column. Scans the alien alive mask for a living column and offers the column to the bullet spawner over a valid/ready handshake.

## Interface
- `LEN`, 16: width of the random input word.
- `COLS`, 11: number of alien columns (≥2). `CW = $clog2(COLS)` (derived, 4 at default).
- `MIN_GAP`, 8: minimum ticks between shots.
- `GAP_BITS`, 5: random extra gap width, taken from `rand[LEN-1 -: GAP_BITS]`.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  game running; low aborts and freezes firing.
- `tick`  in  1  one-cycle frame strobe; advances the cooldown.
- `rand`  in  LEN  current LFSR output.
- `alive`  in  COLS  bit i = column i has at least one living alien.
- `player_col`  in  CW  player column (used only with the macro).
- `fire_valid`  out  1  shot offer.
- `fire_col`  out  CW  firing column; stable while `fire_valid`.
- `fire_ready`  in  1  spawner accepts.

## Operation
- Reset: state COOL, `cnt` = MIN_GAP, `fire_valid`=0, `fire_col`=0, scan index 0, miss count 0.
- COOL: on `tick && enable && cnt!=0`, `cnt` decrements. When `cnt==0 && enable`, go to SCAN and load idx = start column.
- Start column: r = `rand[CW-1:0]`; start = (r ≥ COLS) ? r−COLS : r. A single subtraction suffices because 2^CW < 2·COLS.
- SCAN, one column per cycle, `alive` sampled live:
  - `alive[idx]`=1 → `fire_col`=idx, go to OFFER.
  - otherwise idx = (idx==COLS−1) ? 0 : idx+1 and misses += 1.
  - COLS consecutive misses (mask all zero) → COOL with reload; no shot.
- OFFER: `fire_valid`=1. A transfer occurs on a cycle with `fire_valid && fire_ready`. The next cycle is COOL with reload. `fire_col` is held even if `alive[fire_col]` drops.
- Reload: `cnt` = MIN_GAP + `rand[LEN-1 -: GAP_BITS]`, sampled on the reload cycle. Counter width is `$clog2(MIN_GAP + 2^GAP_BITS)`, with no overflow.
- `enable` low in any state → next cycle COOL, `cnt` = MIN_GAP, `fire_valid`=0. This is the only permitted withdrawal of a pending offer. While low, ticks are ignored.
- `rst` mid-operation overrides everything and restores the reset values on the next edge.

## Timing
- All outputs are registered.
- Cycle t: COOL with `cnt==0`. Cycle t+1: SCAN. Best-case `fire_valid` at t+2.
- Each dead column adds 1 cycle. Worst-case all-dead abort returns to COOL at t+1+COLS.
- `fire_ready` may be asserted before valid; it has no effect until OFFER.
- `tick` coinciding with the cycle that enters COOL does not decrement the freshly reloaded `cnt`.
- `tick` coinciding with `cnt==1` sets `cnt` to 0. Leaving COOL for SCAN then happens on the following cycle, with no tick needed.

## Configuration
- `ALIEN_FIRE_AIMED_EN` defined: on COOL→SCAN, if `rand[CW]`=1 the start column is `player_col`, clamped to COLS−1 if ≥ COLS; otherwise the random start is used. About half of all shots are therefore aimed at the player.
- Not defined: the start is always random and `player_col` is ignored (unconnected logic is removed).

## Test plan
- Reset then idle: `fire_valid`=0 and `fire_col`=0 after reset. With `enable`=1, `alive`=all ones, `rand[3:0]`=13, and 8 ticks: `fire_valid` rises 2 cycles after `cnt` hits 0, with `fire_col`=2.
- Scan wrap: `alive`=11'b000_0000_0001, start 9 → misses at 9 and 10, then `fire_col`=0 after 2 extra cycles.
- Empty mask: `alive`=0 → no `fire_valid` for 11 SCAN cycles, then return to COOL and reload.
- Handshake: hold `fire_ready`=0 for 5 cycles → `fire_valid` and `fire_col` are stable. Pulse ready with `rand[15:11]`=3 → next COOL `cnt`=11, and the next offer comes only after 11 ticks.
- Abort: drop `enable` during OFFER → `fire_valid`=0 next cycle and `cnt`=8. Ticks while `enable` is low do not change `cnt`.
- Macro build: `ALIEN_FIRE_AIMED_EN` defined, `rand[4]`=1, `player_col`=14 → start clamped, so `fire_col`=10 when alive.
